apb4_csr_arbiter: RTL and testbench

//  N-port APB4 arbiter sharing one CSR register-map completer (the APB4 slave + CSR_IP_Map top) between several requesters.
//  - Requesters: e.g. host CPU, debug bridge, boot sequencer.
//  - Round-robin grant; one downstream transfer at a time.
//  - Timeout guard: returns PSLVERR if the completer stalls.

---
 rtl/apb4_csr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_apb4_csr_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_csr_arbiter.sv
// Round-robin APB4 arbiter feeding one CSR completer.
// One downstream transfer at a time, with a stall timeout.
module apb4_csr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              s_psel,
    input  logic [NUM_REQ-1:0]              s_penable,
    input  logic [NUM_REQ-1:0]              s_pwrite,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_pwdata,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_pstrb,
    input  logic [NUM_REQ*3-1:0]            s_pprot,
    output logic [NUM_REQ-1:0]              s_pready,
    output logic [DATA_WIDTH-1:0]           s_prdata,
    output logic                            s_pslverr,
    output logic                            m_psel,
    output logic                            m_penable,
    output logic                            m_pwrite,
    output logic [ADDR_WIDTH-1:0]           m_paddr,
    output logic [DATA_WIDTH-1:0]           m_pwdata,
    output logic [DATA_WIDTH/8-1:0]         m_pstrb,
    output logic [2:0]                      m_pprot,
    input  logic                            m_pready,
    input  logic [DATA_WIDTH-1:0]           m_prdata,
    input  logic                            m_pslverr,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_evt
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IW-1:0]         r_ptr;
    logic [IW-1:0]         r_gnt;
    logic [IW-1:0]         w_win;
    logic [IW-1:0]         w_idx;
    logic                  w_req;
    logic                  w_tmo;
    logic [CW-1:0]         r_cnt;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [SW-1:0]         r_pstrb;
    logic [2:0]            r_pprot;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_tev;
    logic                  w_unused;

    // Request is PSEL in either phase, so PENABLE carries no information.
    assign w_unused = ^s_penable;

    assign w_tmo = (TIMEOUT_CYCLES != 0) &&
                   ((int'(r_cnt) + 1) == TIMEOUT_CYCLES);

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        w_req = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = IW'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_req && s_psel[w_idx]) begin
                w_req = 1'b1;
                w_win = w_idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_req) w_next = S_SETUP;
            S_SETUP:  w_next = S_ACCESS;
            S_ACCESS: if (m_pready || w_tmo) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-state bus strobes and the requester handshake.
    always_comb begin
        m_psel    = 1'b0;
        m_penable = 1'b0;
        busy      = 1'b1;
        s_pready  = '0;
        unique case (r_state)
            S_IDLE:   busy = 1'b0;
            S_SETUP:  m_psel = 1'b1;
            S_ACCESS: begin
                m_psel    = 1'b1;
                m_penable = 1'b1;
            end
            S_RESP:   s_pready[r_gnt] = 1'b1;
            default:  busy = 1'b0;
        endcase
    end

    // Grant capture, timeout count, response latch and pointer advance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= '0;
            r_gnt    <= '0;
            r_cnt    <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pstrb  <= '0;
            r_pprot  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_tev    <= 1'b0;
        end else begin
            r_tev <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_gnt    <= w_win;
                        r_pwrite <= s_pwrite[w_win];
                        r_paddr  <= s_paddr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_pwdata <= s_pwdata[int'(w_win)*DATA_WIDTH +: DATA_WIDTH];
                        r_pstrb  <= s_pstrb[int'(w_win)*SW +: SW];
                        r_pprot  <= s_pprot[int'(w_win)*3 +: 3];
                    end
                end
                S_SETUP: r_cnt <= '0;
                S_ACCESS: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (m_pready) begin
                        r_rdata <= m_prdata;
                        r_err   <= m_pslverr;
                    end else if (w_tmo) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_tev   <= 1'b1;
                    end
                end
                S_RESP:  r_ptr <= IW'((int'(r_gnt) + 1) % NUM_REQ);
                default: ;
            endcase
        end
    end

    assign m_pwrite    = r_pwrite;
    assign m_paddr     = r_paddr;
    assign m_pwdata    = r_pwdata;
    assign m_pstrb     = r_pstrb;
    assign m_pprot     = r_pprot;
    assign s_prdata    = r_rdata;
    assign s_pslverr   = r_err;
    assign grant_id    = r_gnt;
    assign timeout_evt = r_tev;

endmodule

// File: tb/tb_apb4_csr_arbiter.sv
// Bench for apb4_csr_arbiter: transaction-level model plus
// directed scenarios with hand-computed latencies.
module tb_apb4_csr_arbiter;

    localparam int N   = 2;
    localparam int AW  = 3;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;
    localparam int IW  = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_psel, s_penable, s_pwrite;
    logic [N*AW-1:0] s_paddr;
    logic [N*DW-1:0] s_pwdata;
    logic [N*SW-1:0] s_pstrb;
    logic [N*3-1:0]  s_pprot;
    logic [N-1:0]    s_pready;
    logic [DW-1:0]   s_prdata;
    logic            s_pslverr;
    logic            m_psel, m_penable, m_pwrite;
    logic [AW-1:0]   m_paddr;
    logic [DW-1:0]   m_pwdata;
    logic [SW-1:0]   m_pstrb;
    logic [2:0]      m_pprot;
    logic            m_pready;
    logic [DW-1:0]   m_prdata;
    logic            m_pslverr;
    logic [IW-1:0]   grant_id;
    logic            busy, timeout_evt;

    apb4_csr_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
        .s_pprot(s_pprot), .s_pready(s_pready), .s_prdata(s_prdata),
        .s_pslverr(s_pslverr), .m_psel(m_psel), .m_penable(m_penable),
        .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pstrb(m_pstrb), .m_pprot(m_pprot), .m_pready(m_pready),
        .m_prdata(m_prdata), .m_pslverr(m_pslverr), .grant_id(grant_id),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Completer: ready after cw wait states, fixed data/error.
    int            cw      = 0;
    int            c_cnt   = 0;
    logic [DW-1:0] c_rdata = '0;
    logic          c_err   = 1'b0;
    logic          cap_w;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;
    logic [SW-1:0] cap_s;
    logic [2:0]    cap_p;

    always @(posedge clk) begin
        #1;
        if (rst && m_psel && m_penable) begin
            if (c_cnt == 0) begin
                cap_w = m_pwrite; cap_a = m_paddr; cap_d = m_pwdata;
                cap_s = m_pstrb;  cap_p = m_pprot;
            end
            m_pready  = (c_cnt == cw);
            m_prdata  = c_rdata;
            m_pslverr = c_err;
            c_cnt++;
        end else begin
            m_pready = 1'b0;
            c_cnt    = 0;
        end
    end

    // Requester agents: raise PENABLE, drop after the ready cycle.
    logic [N-1:0] rdy_seen = '0;

    always @(negedge clk)
        for (int i = 0; i < N; i++) if (s_pready[i]) rdy_seen[i] = 1'b1;

    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++) begin
            if (rdy_seen[i]) begin
                rdy_seen[i]  = 1'b0;
                s_psel[i]    = 1'b0;
                s_penable[i] = 1'b0;
            end else if (s_psel[i]) begin
                s_penable[i] = 1'b1;
            end
        end
    end

    // Transaction-level model: each grant yields SETUP, then
    // min(waits+1, TMO) ACCESS cycles, then one response cycle.
    bit            mb = 0;
    int            mt, mg, mA, mptr = 0, idx;
    bit            mtmo;
    logic          mw, mer, e_er = 1'b0;
    logic [AW-1:0] ma;
    logic [DW-1:0] md, mrd, e_rd = '0;
    logic [SW-1:0] ms;
    logic [2:0]    mp;
    logic [IW-1:0] e_gid = '0;
    logic [N-1:0]  oh;

    always @(negedge clk) begin
        if (!rst) begin
            mb = 0; mptr = 0; e_gid = '0; e_rd = '0; e_er = 1'b0;
            chk("rst_ctl", {busy, m_psel, m_penable, m_pwrite, timeout_evt,
                            s_pslverr, s_pready, grant_id}, 0);
            chk("rst_bus", {m_pprot, m_pstrb, m_paddr, m_pwdata}, 0);
            chk("rst_rdata", s_prdata, 0);
        end else if (!mb) begin
            chk("idle_ctl", {busy, m_psel, m_penable, timeout_evt, s_pready}, 0);
            chk("idle_resp", {s_pslverr, s_prdata}, {e_er, e_rd});
            chk("idle_gid", grant_id, e_gid);
            for (int k = 0; k < N; k++) begin
                idx = (mptr + k) % N;
                if (!mb && s_psel[idx]) begin
                    mb = 1; mt = 1; mg = idx;
                    mw = s_pwrite[idx];
                    ma = s_paddr[idx*AW +: AW];
                    md = s_pwdata[idx*DW +: DW];
                    ms = s_pstrb[idx*SW +: SW];
                    mp = s_pprot[idx*3 +: 3];
                    mtmo = (cw + 1 > TMO);
                    mA   = mtmo ? TMO : cw + 1;
                    mrd  = mtmo ? '0 : c_rdata;
                    mer  = mtmo ? 1'b1 : c_err;
                end
            end
            if (mb) e_gid = IW'(mg);
        end else begin
            chk("busy", busy, 1);
            chk("gid", grant_id, mg);
            if (mt < 2 + mA) begin
                chk("m_phase", {m_psel, m_penable, s_pready, timeout_evt},
                    {1'b1, (mt > 1), {N{1'b0}}, 1'b0});
                chk("m_payload", {m_pwrite, m_pprot, m_pstrb, m_paddr, m_pwdata},
                    {mw, mp, ms, ma, md});
            end else begin
                oh = N'(1) << mg;
                chk("resp_ctl", {m_psel, m_penable, s_pready, timeout_evt},
                    {2'b00, oh, mtmo});
                chk("resp_data", {s_pslverr, s_prdata}, {mer, mrd});
                e_rd = mrd; e_er = mer; mptr = (mg + 1) % N; mb = 0;
            end
            mt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input bit wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] st,
                         input logic [2:0] pr);
        s_psel[i]           = 1'b1;
        s_penable[i]        = 1'b0;
        s_pwrite[i]         = wr;
        s_paddr[i*AW +: AW] = a;
        s_pwdata[i*DW +: DW] = d;
        s_pstrb[i*SW +: SW] = st;
        s_pprot[i*3 +: 3]   = pr;
    endtask

    task automatic wait_rdy(input int i, input int budget, output int c,
                            output logic [DW-1:0] rd, output logic er,
                            output logic te);
        int n = 0;
        c = -1; rd = '0; er = 1'b0; te = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            if (s_pready[i]) begin
                c = cyc; rd = s_prdata; er = s_pslverr; te = timeout_evt;
                break;
            end
            n++;
        end
        if (c < 0) begin
            total++; bad++;
            $display("FAIL wait_rdy req%0d: no s_pready within %0d cycles", i, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, c;
        logic [DW-1:0] rd;
        logic er, te;
        rst = 1'b1;
        s_psel = '0; s_penable = '0; s_pwrite = '0; s_paddr = '0;
        s_pwdata = '0; s_pstrb = '0; s_pprot = '0;
        m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        step(); rst = 1'b1;
        step();

        // Contention from reset: req0 then req1.
        cw = 0; c_rdata = 32'h1111_0000; c_err = 1'b0;
        step();
        issue(0, 0, 3'd1, 32'h0, 4'h0, 3'd0);
        issue(1, 0, 3'd2, 32'h0, 4'h0, 3'd1);
        t0 = cyc;
        wait_rdy(0, 40, c, rd, er, te); chk("pair0_req0_lat", c - t0, 3);
        wait_rdy(1, 40, c, rd, er, te); chk("pair0_req1_lat", c - t0, 7);
        step(); step();

        // Single read, zero waits.
        c_rdata = 32'hDEADBEEF;
        issue(0, 0, 3'd3, 32'h0, 4'h0, 3'd0); t0 = cyc;
        wait_rdy(0, 40, c, rd, er, te);
        chk("rd_lat", c - t0, 3);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", er, 0);
        step(); step();

        // Write passthrough from req1.
        c_rdata = '0;
        issue(1, 1, 3'd5, 32'h12345678, 4'b0011, 3'b010); t0 = cyc;
        wait_rdy(1, 40, c, rd, er, te);
        chk("wr_lat", c - t0, 3);
        chk("wr_bus", {cap_w, cap_p, cap_s, cap_a, cap_d},
            {1'b1, 3'b010, 4'b0011, 3'd5, 32'h12345678});
        step(); step();

        // Completer stall -> timeout.
        cw = 100; c_rdata = 32'hCAFE_F00D;
        issue(0, 0, 3'd7, 32'h0, 4'h0, 3'd0); t0 = cyc;
        wait_rdy(0, 60, c, rd, er, te);
        chk("tmo_lat", c - t0, 18);
        chk("tmo_evt", te, 1);
        chk("tmo_resp", {er, rd}, {1'b1, 32'h0});
        chk("tmo_mpsel", m_psel, 0);
        step(); step();

        // Pointer now 1: simultaneous pair serves req1 first.
        cw = 0; c_rdata = 32'h0000_00A5;
        issue(0, 0, 3'd4, 32'h0, 4'h0, 3'd0);
        issue(1, 0, 3'd6, 32'h0, 4'h0, 3'd0);
        t0 = cyc;
        wait_rdy(1, 40, c, rd, er, te); chk("pair1_req1_lat", c - t0, 3);
        wait_rdy(0, 40, c, rd, er, te); chk("pair1_req0_lat", c - t0, 7);
        step(); step();

        // Three wait states then error.
        cw = 3; c_rdata = 32'hBAD0_0005; c_err = 1'b1;
        issue(1, 0, 3'd2, 32'h0, 4'h0, 3'd0); t0 = cyc;
        wait_rdy(1, 40, c, rd, er, te);
        chk("ws_lat", c - t0, 6);
        chk("ws_resp", {er, rd}, {1'b1, 32'hBAD0_0005});
        step(); step();

        // Early PSEL drop: transfer still completes.
        cw = 2; c_err = 1'b0; c_rdata = 32'h0000_7777;
        issue(0, 0, 3'd1, 32'h0, 4'h0, 3'd0); t0 = cyc;
        step(); s_psel[0] = 1'b0; s_penable[0] = 1'b0;
        wait_rdy(0, 40, c, rd, er, te);
        chk("drop_lat", c - t0, 5);
        chk("drop_data", rd, 32'h0000_7777);
        step(); step();

        // Reset in the middle of ACCESS.
        cw = 5;
        issue(1, 0, 3'd3, 32'h0, 4'h0, 3'd0);
        step(); step();
        chk("rst_mid_access", {m_psel, m_penable}, 2'b11);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_ctl", {busy, m_psel, m_penable, s_pready, grant_id, s_pslverr}, 0);
        chk("rst_async_data", s_prdata, 0);
        s_psel = '0; s_penable = '0;
        @(negedge clk);
        step(); rst = 1'b1;
        cw = 0; c_rdata = 32'h5555_AAAA;
        step();
        issue(0, 0, 3'd0, 32'h0, 4'h0, 3'd0);
        issue(1, 0, 3'd1, 32'h0, 4'h0, 3'd0);
        t0 = cyc;
        wait_rdy(0, 40, c, rd, er, te); chk("post_rst_req0_lat", c - t0, 3);
        wait_rdy(1, 40, c, rd, er, te); chk("post_rst_req1_lat", c - t0, 7);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
